// File: rtl/arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Byte-enable width for a data bus; the all-ones mask is built from this.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_age_counter.sv
// Fetch starvation counter: counts data wins over a waiting fetch and
// raises force_o at STARVE_LIMIT. Used only when ARB_FETCH_AGE_EN is defined.
`default_nettype none

module arb_age_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic d_win_i,
  input  logic if_win_i,
  output logic force_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (if_win_i) begin
      cnt_d = '0;
    end else if (if_req_i && d_win_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter: data (MEM stage) over instruction fetch.
// Optional fetch anti-starvation aging via macro ARB_FETCH_AGE_EN.
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = be_width(DATA_W);
  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  arb_state_t        state_q, state_d;
  arb_owner_t        owner;
  logic              arb_pt;
  logic              fetch_force;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              if_rvalid_q, d_done_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // The ack cycle is also an arbitration point, giving back-to-back accesses.
  assign arb_pt = (state_q == ARB_IDLE) || mem_ack;
  assign owner  = (state_q == ARB_D) ? OWN_D : OWN_IF;

`ifdef ARB_FETCH_AGE_EN
  logic age_force;

  arb_age_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req_i (if_req),
    .d_win_i  (d_gnt),
    .if_win_i (if_gnt),
    .force_o  (age_force)
  );

  assign fetch_force = age_force && if_req;
`else
  logic unused_starve;
  assign unused_starve = STARVE_LIMIT[0];
  assign fetch_force   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    d_gnt   = 1'b0;
    if_gnt  = 1'b0;
    if (arb_pt) begin
      if (d_req && !fetch_force) begin
        d_gnt   = 1'b1;
        state_d = ARB_D;
      end else if (if_req) begin
        if_gnt  = 1'b1;
        state_d = ARB_IF;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (d_gnt) begin
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        mem_be_q    <= d_be;
      end else if (if_gnt) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= BE_ALL;
      end
    end
  end

  // Completion: an ack in IDLE is ignored; stores leave d_rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if (mem_ack && (state_q != ARB_IDLE)) begin
        if (owner == OWN_IF) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_rdata;
        end else begin
          d_done_q <= 1'b1;
          if (!mem_we_q) d_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = (state_q != ARB_IDLE);
  assign busy      = (state_q != ARB_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a transaction-level reference.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          if_req = 1'b0, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_gnt, d_done;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic [BW-1:0] d_be = '0;
  logic          mem_req, mem_we, mem_ack = 1'b0, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [BW-1:0] mem_be;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            own_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } acc_t;

  typedef struct {
    bit            own_d;
    bit            we;
    logic [DW-1:0] data;
    longint        due;
  } cmp_t;

  acc_t          mem_q[$];
  cmp_t          comp_q[$];
  int            total = 0, bad = 0;
  longint        cyc = 0;
  bit            m_busy = 0;
  int            m_losses = 0;
  logic [DW-1:0] m_last_if = '0, m_last_d = '0;
  int            fetch_grants = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // One cycle of stimulus; grants and memory-side behaviour are checked here,
  // completions are queued for the monitor.
  task automatic drive_cycle(input bit ifr, input bit dr, input bit ack);
    bit   arb, force_if, exp_d, exp_if;
    acc_t a;
    cmp_t c;
    @(negedge clk);
    if_req    = ifr;
    if_addr   = $urandom;
    d_req     = dr;
    d_we      = 1'($urandom_range(0, 1));
    d_addr    = $urandom;
    d_wdata   = $urandom;
    d_be      = BW'($urandom);
    mem_ack   = ack;
    mem_rdata = $urandom;
    #1;
    arb = !m_busy || ack;
`ifdef ARB_FETCH_AGE_EN
    force_if = (m_losses >= LIMIT) && ifr;
`else
    force_if = 1'b0;
`endif
    exp_d  = arb && dr && !force_if;
    exp_if = arb && ifr && !exp_d;
    check("d_gnt", d_gnt, exp_d);
    check("if_gnt", if_gnt, exp_if);
    check("mem_req", mem_req, m_busy);
    check("busy", busy, m_busy);
    if (m_busy) begin
      a = mem_q[0];
      check("mem_addr", mem_addr, a.addr);
      check("mem_we", mem_we, a.we);
      check("mem_be", mem_be, a.be);
      if (a.we) check("mem_wdata", mem_wdata, a.wdata);
      if (ack) begin
        void'(mem_q.pop_front());
        c.own_d = a.own_d; c.we = a.we; c.data = mem_rdata; c.due = cyc + 1;
        comp_q.push_back(c);
      end
    end
    if (exp_d) begin
      a.own_d = 1; a.we = d_we; a.addr = d_addr; a.wdata = d_wdata; a.be = d_be;
      mem_q.push_back(a);
      if (ifr) m_losses++;
    end
    if (exp_if) begin
      a.own_d = 0; a.we = 0; a.addr = if_addr; a.wdata = '0; a.be = '1;
      mem_q.push_back(a);
      m_losses = 0;
      fetch_grants++;
    end
    if (exp_d || exp_if) m_busy = 1;
    else if (ack)        m_busy = 0;
  endtask

  // Completion monitor: a pulse must appear exactly one cycle after its ack.
  initial forever begin
    cmp_t c;
    bit   due;
    @(posedge clk);
    #1;
    due = (comp_q.size() > 0) && (comp_q[0].due == cyc);
    check("if_rvalid", if_rvalid, due && !comp_q[0].own_d);
    check("d_done", d_done, due && comp_q[0].own_d);
    if (due) begin
      c = comp_q.pop_front();
      if (c.own_d && !c.we) m_last_d = c.data;
      if (!c.own_d)         m_last_if = c.data;
    end
    check("if_rdata", if_rdata, m_last_if);
    check("d_rdata", d_rdata, m_last_d);
  end

  task automatic drain();
    for (int i = 0; i < 8 && m_busy; i++) drive_cycle(0, 0, 1);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 0);
  endtask

  initial begin
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch alone with one-cycle ack.
    drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 1);
    drive_cycle(0, 0, 0);

    // Simultaneous requests: data wins, fetch follows in the ack cycle.
    drive_cycle(1, 1, 0);
    drive_cycle(1, 0, 0);
    drive_cycle(1, 0, 1);
    drive_cycle(0, 0, 1);
    drain();

    // Load with three wait cycles.
    drive_cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0);
    drive_cycle(0, 0, 1);
    drain();

    // Sustained contention with zero-wait memory.
    fetch_grants = 0;
    drive_cycle(1, 1, 0);
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, 1);
`ifdef ARB_FETCH_AGE_EN
    check("aged_fetch_grants", fetch_grants, 2);
`else
    check("starved_fetch_grants", fetch_grants, 0);
`endif
    drain();

    // Ack while idle is ignored.
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      drive_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 1) == 1);
    drain();

    // Reset in the middle of a data access, before its ack.
    drive_cycle(0, 1, 0);
    drive_cycle(0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_mem_req", mem_req, 0);
    check("rst_async_busy", busy, 0);
    m_busy = 0; m_losses = 0; m_last_if = '0; m_last_d = '0;
    mem_q.delete();
    comp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1);
    for (int i = 0; i < 200; i++)
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
    drain();

    check("pending_completions", comp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
